// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 RISC-V integer register file with x10 (a0) observation output
// Optional REGFILE_BYPASS_EN: same-cycle write-through forwarding on both read ports.
module reg_file #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] ad1,
    input  logic [ADDR_WIDTH-1:0] ad2,
    input  logic [ADDR_WIDTH-1:0] ad3,
    input  logic                  we3,
    input  logic [DATA_WIDTH-1:0] wd3,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    output logic [DATA_WIDTH-1:0] a0
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] A0_IDX = ADDR_WIDTH'(10);
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = '0;

    logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_a0;
    logic                  w_wr_en;
    logic                  w_wr_a0;

    // x0 is never written, so it stays at its reset value of zero.
    assign w_wr_en = we3 && (ad3 != ZERO_IDX);
    assign w_wr_a0 = w_wr_en && (ad3 == A0_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
            r_a0 <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[ad3] <= wd3;
            end
            r_a0 <= w_wr_a0 ? wd3 : r_mem[A0_IDX];
        end
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ad1 != ZERO_IDX) begin
            rd1 = (w_wr_en && (ad1 == ad3)) ? wd3 : r_mem[ad1];
        end
        if (ad2 != ZERO_IDX) begin
            rd2 = (w_wr_en && (ad2 == ad3)) ? wd3 : r_mem[ad2];
        end
    end
`else
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ad1 != ZERO_IDX) begin
            rd1 = r_mem[ad1];
        end
        if (ad2 != ZERO_IDX) begin
            rd2 = r_mem[ad2];
        end
    end
`endif

    assign a0 = r_a0;

endmodule
